// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared pipeline definitions: register-index width, control-bundle layout,
// the NOP encoding and the ID/EX FSM state codes.
package id_ex_pipeline_reg_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 8;

  // Control bundle bit positions, MSB first: reg_write .. wb_sel[1:0]
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_WB_SEL_HI = 1;
  localparam int CTRL_WB_SEL_LO = 0;

  localparam logic [CTRL_W-1:0]    CTRL_NOP = '0;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/id_ex_pipeline_reg_wb_forward_latch.sv
// Per-operand pending-forward flag: captured on the RUN->STALL bubble,
// consumed on the STALL cycle, where the operand is replaced by wb_data.
module wb_forward_latch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_i,
  input  logic                  fwd_en_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] id_data_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  pend_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = pend_q;
    if (capture_i) begin
      pend_d = fwd_en_i;
    end else if (clear_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign data_o = pend_q ? wb_data_i : id_data_i;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with one-cycle load-use bubble, WB forwarding on
// the replay cycle, flush-to-NOP and saturating bubble/flush event counters.
module id_ex_pipeline_reg
  import id_ex_pipeline_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_bubble,
  input  logic                  enable_rs1_forward_from_wb,
  input  logic                  enable_rs2_forward_from_wb,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_IDX_W-1:0]  id_rs1,
  input  logic [REG_IDX_W-1:0]  id_rs2,
  input  logic [REG_IDX_W-1:0]  id_rd,
  input  logic [CTRL_W-1:0]     id_ctrl,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_IDX_W-1:0]  ex_rs1,
  output logic [REG_IDX_W-1:0]  ex_rs2,
  output logic [REG_IDX_W-1:0]  ex_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic [CNT_WIDTH-1:0]  bubble_count,
  output logic [CNT_WIDTH-1:0]  flush_count,
  output logic [0:0]            dbg_state_o,
  output logic [1:0]            dbg_pend_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_IDX_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

  logic                  in_stall;
  logic                  take_bubble;
  logic                  load_nop;
  logic                  rs1_pend, rs2_pend;
  logic [DATA_WIDTH-1:0] rs1_sel, rs2_sel;

  assign in_stall    = (state_q == ST_STALL);
  // A bubble can only start from RUN; a flush always wins over it.
  assign take_bubble = !in_stall && enable_bubble && !flush;
  assign load_nop    = flush || take_bubble;

  wb_forward_latch #(.DATA_WIDTH(DATA_WIDTH)) u_rs1_fwd (
    .clk       (clk),
    .reset     (reset),
    .capture_i (take_bubble),
    .fwd_en_i  (enable_rs1_forward_from_wb),
    .clear_i   (in_stall),
    .id_data_i (id_rs1_data),
    .wb_data_i (wb_data),
    .pend_o    (rs1_pend),
    .data_o    (rs1_sel)
  );

  wb_forward_latch #(.DATA_WIDTH(DATA_WIDTH)) u_rs2_fwd (
    .clk       (clk),
    .reset     (reset),
    .capture_i (take_bubble),
    .fwd_en_i  (enable_rs2_forward_from_wb),
    .clear_i   (in_stall),
    .id_data_i (id_rs2_data),
    .wb_data_i (wb_data),
    .pend_o    (rs2_pend),
    .data_o    (rs2_sel)
  );

  always_comb begin
    state_d      = take_bubble ? ST_STALL : ST_RUN;
    pc_d         = id_pc;
    rs1_data_d   = rs1_sel;
    rs2_data_d   = rs2_sel;
    imm_d        = id_imm;
    rs1_d        = id_rs1;
    rs2_d        = id_rs2;
    rd_d         = id_rd;
    ctrl_d       = id_ctrl;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (load_nop) begin
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = REG_ZERO;
      rs2_d      = REG_ZERO;
      rd_d       = REG_ZERO;
      ctrl_d     = CTRL_NOP;
    end
    if (take_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= REG_ZERO;
      rs2_q        <= REG_ZERO;
      rd_q         <= REG_ZERO;
      ctrl_q       <= CTRL_NOP;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Hold IF and ID only while the bubble is being inserted.
  assign pc_write_en   = reset || !take_bubble;
  assign ifid_write_en = reset || !take_bubble;

  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign bubble_count  = bubble_cnt_q;
  assign flush_count   = flush_cnt_q;
  assign dbg_state_o   = state_q;
  assign dbg_pend_o    = {rs2_pend, rs1_pend};

endmodule
